retire_trace_buffer: RTL and testbench

Downstream consumer of the single-cycle core's per-cycle retirement outputs (pc, instruction, reg_write, rd address, write data). It captures one retirement record per clock into a synchronous FIFO. It then serializes each record as four 32-bit words over a valid/ready stream for a debug drain (UART bridge or testbench monitor). Drops on full are counted, and a sequence number is embedded in every record so gaps are detectable.

---
 rtl/retire_trace_buffer_pkg.sv | 34 +++
 rtl/retire_trace_buffer_fifo.sv | 65 ++++++
 rtl/retire_trace_buffer.sv | 112 +++++++++++
 tb/tb_retire_trace_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_trace_buffer_pkg.sv
// Shared layout definitions for the retirement trace record and its serialized words.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package retire_trace_buffer_pkg;

    localparam int SEQ_W = 24;
    localparam int REC_W = 126;   // 32 pc + 32 instr + 24 seq + 1 rw + 5 rd + 32 data

    // Serializer word order within one record
    localparam logic [1:0] WORD_PC    = 2'd0;
    localparam logic [1:0] WORD_INSTR = 2'd1;
    localparam logic [1:0] WORD_META  = 2'd2;
    localparam logic [1:0] WORD_DATA  = 2'd3;

    // Meta word field layout: {seq[23:0], reg_write, 2'b00, rd[4:0]}
    localparam int META_RD_LSB  = 0;
    localparam int META_RD_W    = 5;
    localparam int META_RW_BIT  = 7;
    localparam int META_SEQ_LSB = 8;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [SEQ_W-1:0] seq;
        logic             reg_write;
        logic [4:0]       rd;
        logic [31:0]      data;
    } trace_rec_t;

    function automatic logic [31:0] meta_word(input trace_rec_t r);
        return {r.seq, r.reg_write, 2'b00, r.rd};
    endfunction

endpackage

// File: rtl/retire_trace_buffer_fifo.sv
// Generic synchronous FIFO: registered storage, head entry read combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
//
// Ports: clock/reset (sync, active-high); push + push_dat write at tail;
// pop removes head; head_dat is the current head; full/empty/count status.
module retire_trace_buffer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    // Storage carries no reset; validity is tracked purely by count.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves count unchanged.
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures one core retirement record per cycle and drains it as four 32-bit words.
// Latency: record pushed at edge N presents word 0 from cycle N+1 when empty.
// Backpressure: out_valid/out_ready; words held stable while stalled, captures dropped and counted when full.
//
// Ports: clock, reset (sync, active-high); enable + in_* retirement record;
// out_valid/out_ready/out_data/out_last word stream; count/full/empty FIFO
// status (count includes a partially sent record); overflow_count saturating drops.
module retire_trace_buffer
    import retire_trace_buffer_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int FILTER_WB = 0,
    parameter int OVF_W     = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [31:0]             in_pc,
    input  logic [31:0]             in_instruction,
    input  logic                    in_reg_write,
    input  logic [4:0]              in_rd_address,
    input  logic [31:0]             in_write_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data,
    output logic                    out_last,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic [OVF_W-1:0]        overflow_count
);

    logic             cap;
    logic             push;
    logic             drop;
    logic             xfer;
    logic             pop;
    logic [1:0]       word_idx;
    logic [SEQ_W-1:0] seq;
    logic [31:0]      word;
    trace_rec_t       new_rec;
    trace_rec_t       head;
    logic [REC_W-1:0] head_dat;

    // With write-back filtering only records that actually update a
    // register are interesting; x0 writes are architectural no-ops.
    assign cap  = enable && ((FILTER_WB == 0) || (in_reg_write && (in_rd_address != 5'd0)));
    assign push = cap && !full;
    assign drop = cap && full;   // a same-cycle pop does not free a slot in time

    assign new_rec = '{pc:        in_pc,
                       instr:     in_instruction,
                       seq:       seq,
                       reg_write: in_reg_write,
                       rd:        in_rd_address,
                       data:      in_write_data};

    assign out_valid = !empty;
    assign out_last  = out_valid && (word_idx == WORD_DATA);
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (word_idx == WORD_DATA);

    retire_trace_buffer_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (new_rec),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign head = trace_rec_t'(head_dat);

    always_comb begin
        word = '0;
        case (word_idx)
            WORD_PC:    word = head.pc;
            WORD_INSTR: word = head.instr;
            WORD_META:  word = meta_word(head);
            WORD_DATA:  word = head.data;
            default:    word = '0;
        endcase
    end

    // Keep the bus quiet when nothing is offered rather than exposing stale storage.
    assign out_data = out_valid ? word : 32'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            word_idx       <= WORD_PC;
            seq            <= '0;
            overflow_count <= '0;
        end else begin
            if (push) begin
                seq <= seq + 1'b1;
            end
            if (drop && (overflow_count != {OVF_W{1'b1}})) begin
                overflow_count <= overflow_count + 1'b1;
            end
            if (xfer) begin
                word_idx <= (word_idx == WORD_DATA) ? WORD_PC : word_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
module tb_retire_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        en_a, en_b, rdy_a, rdy_b;
    logic [31:0] in_pc, in_instr, in_data;
    logic        in_rw;
    logic [4:0]  in_rd;

    logic        valid_a, last_a, full_a, empty_a;
    logic [31:0] data_a;
    logic [2:0]  count_a;
    logic [2:0]  ovf_a;
    logic        valid_b, last_b, full_b, empty_b;
    logic [31:0] data_b;
    logic [2:0]  count_b;
    logic [15:0] ovf_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    // Unfiltered, small depth, narrow overflow counter so saturation is reachable.
    retire_trace_buffer #(.DEPTH(4), .FILTER_WB(0), .OVF_W(3)) u_dut (
        .clock(clock), .reset(reset), .enable(en_a),
        .in_pc(in_pc), .in_instruction(in_instr), .in_reg_write(in_rw),
        .in_rd_address(in_rd), .in_write_data(in_data),
        .out_valid(valid_a), .out_ready(rdy_a), .out_data(data_a), .out_last(last_a),
        .count(count_a), .full(full_a), .empty(empty_a), .overflow_count(ovf_a)
    );

    // Write-back filtered instance.
    retire_trace_buffer #(.DEPTH(4), .FILTER_WB(1), .OVF_W(16)) u_filt (
        .clock(clock), .reset(reset), .enable(en_b),
        .in_pc(in_pc), .in_instruction(in_instr), .in_reg_write(in_rw),
        .in_rd_address(in_rd), .in_write_data(in_data),
        .out_valid(valid_b), .out_ready(rdy_b), .out_data(data_b), .out_last(last_b),
        .count(count_b), .full(full_b), .empty(empty_b), .overflow_count(ovf_b)
    );

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic do_reset;
        reset = 1'b1; en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic [31:0] instr,
                           input logic rw, input logic [4:0] rd, input logic [31:0] d);
        in_pc = pc; in_instr = instr; in_rw = rw; in_rd = rd; in_data = d;
    endtask

    // Standard numbered record i: pc 0x100+i, instr 0x1000+i, rw=1, rd=i+1, data 0xD000+i.
    task automatic load_rec(input int i);
        set_rec(32'h100 + 32'(i), 32'h1000 + 32'(i), 1'b1, 5'(i + 1), 32'hD000 + 32'(i));
    endtask

    // Expected word w of numbered record i carrying sequence number seq.
    function automatic logic [31:0] rec_word(input int i, input int w, input int seq);
        case (w)
            0:       return 32'h100 + 32'(i);
            1:       return 32'h1000 + 32'(i);
            2:       return (32'(seq) << 8) | 32'h80 | 32'(i + 1);
            default: return 32'hD000 + 32'(i);
        endcase
    endfunction

    task automatic test_reset;
        set_rec($urandom, $urandom, 1'b1, 5'd7, $urandom);
        en_a = 1'b1; en_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        reset = 1'b1;
        tick();
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        n_cmp++; if (empty_a !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty_a); end
        n_cmp++; if (full_a !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full_a); end
        n_cmp++; if (count_a !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count_a); end
        n_cmp++; if (ovf_a !== 3'd0) begin n_err++; $display("FAIL reset_ovf: got %0d want 0", ovf_a); end
        n_cmp++; if (last_a !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", last_a); end
        n_cmp++; if (valid_b !== 1'b0) begin n_err++; $display("FAIL reset_valid_b: got %b want 0", valid_b); end
        reset = 1'b0; en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    endtask

    task automatic test_single_push;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h00000010; exp_w[1] = 32'h00500093;
        exp_w[2] = 32'h00000081; exp_w[3] = 32'h00000005;
        do_reset();
        set_rec(32'h10, 32'h00500093, 1'b1, 5'd1, 32'h5);
        en_a = 1'b1; rdy_a = 1'b1;
        tick();
        en_a = 1'b0;
        for (int w = 0; w < 4; w++) begin
            n_cmp++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL single_valid w%0d: got %b want 1", w, valid_a); end
            n_cmp++; if (data_a !== exp_w[w]) begin n_err++; $display("FAIL single_data w%0d: got %h want %h", w, data_a, exp_w[w]); end
            n_cmp++; if (last_a !== (w == 3)) begin n_err++; $display("FAIL single_last w%0d: got %b want %b", w, last_a, (w == 3)); end
            tick();
        end
        n_cmp++; if (empty_a !== 1'b1) begin n_err++; $display("FAIL single_empty_after: got %b want 1", empty_a); end
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL single_valid_after: got %b want 0", valid_a); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h00000010; exp_w[1] = 32'h00500093;
        exp_w[2] = 32'h00000081; exp_w[3] = 32'h00000005;
        do_reset();
        set_rec(32'h10, 32'h00500093, 1'b1, 5'd1, 32'h5);
        en_a = 1'b1; rdy_a = 1'b0;
        tick();
        en_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (data_a !== 32'h10) begin n_err++; $display("FAIL bp_hold_data c%0d: got %h want 00000010", k, data_a); end
            n_cmp++; if (valid_a !== 1'b1 || last_a !== 1'b0) begin n_err++; $display("FAIL bp_hold_flags c%0d: got valid=%b last=%b want 1/0", k, valid_a, last_a); end
            n_cmp++; if (count_a !== 3'd1) begin n_err++; $display("FAIL bp_hold_count c%0d: got %0d want 1", k, count_a); end
            tick();
        end
        rdy_a = 1'b1;
        for (int w = 0; w < 4; w++) begin
            n_cmp++; if (data_a !== exp_w[w]) begin n_err++; $display("FAIL bp_data w%0d: got %h want %h", w, data_a, exp_w[w]); end
            n_cmp++; if (count_a !== 3'd1) begin n_err++; $display("FAIL bp_count w%0d: got %0d want 1", w, count_a); end
            n_cmp++; if (last_a !== (w == 3)) begin n_err++; $display("FAIL bp_last w%0d: got %b want %b", w, last_a, (w == 3)); end
            tick();
        end
        n_cmp++; if (count_a !== 3'd0) begin n_err++; $display("FAIL bp_count_after: got %0d want 0", count_a); end
    endtask

    task automatic test_overflow;
        logic [2:0] exp_cnt;
        do_reset();
        rdy_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            load_rec(i);
            en_a = 1'b1;
            tick();
            exp_cnt = (i < 3) ? 3'(i + 1) : 3'd4;
            n_cmp++; if (full_a !== (i >= 3)) begin n_err++; $display("FAIL ovf_full c%0d: got %b want %b", i, full_a, (i >= 3)); end
            n_cmp++; if (count_a !== exp_cnt) begin n_err++; $display("FAIL ovf_count c%0d: got %0d want %0d", i, count_a, exp_cnt); end
        end
        n_cmp++; if (ovf_a !== 3'd2) begin n_err++; $display("FAIL ovf_count_2: got %0d want 2", ovf_a); end
        // Disabled cycles while full must not count as drops.
        en_a = 1'b0;
        repeat (3) tick();
        n_cmp++; if (ovf_a !== 3'd2) begin n_err++; $display("FAIL ovf_disabled: got %0d want 2", ovf_a); end
        n_cmp++; if (count_a !== 3'd4) begin n_err++; $display("FAIL ovf_disabled_count: got %0d want 4", count_a); end
        // Drain record 0; capture on its final-word pop is still dropped.
        rdy_a = 1'b1;
        for (int w = 0; w < 4; w++) begin
            n_cmp++; if (data_a !== rec_word(0, w, 0)) begin n_err++; $display("FAIL ovf_r0 w%0d: got %h want %h", w, data_a, rec_word(0, w, 0)); end
            if (w == 3) begin
                set_rec(32'hBAD, 32'hBAD, 1'b1, 5'd9, 32'hBAD);
                en_a = 1'b1;
            end
            tick();
        end
        en_a = 1'b0;
        n_cmp++; if (count_a !== 3'd3) begin n_err++; $display("FAIL ovf_pop_drop_count: got %0d want 3", count_a); end
        n_cmp++; if (ovf_a !== 3'd3) begin n_err++; $display("FAIL ovf_pop_drop_ovf: got %0d want 3", ovf_a); end
        for (int r = 1; r < 4; r++) begin
            for (int w = 0; w < 4; w++) begin
                n_cmp++; if (valid_a !== 1'b1 || data_a !== rec_word(r, w, r)) begin n_err++; $display("FAIL ovf_drain r%0d w%0d: got valid=%b data=%h want 1/%h", r, w, valid_a, data_a, rec_word(r, w, r)); end
                tick();
            end
        end
        n_cmp++; if (empty_a !== 1'b1) begin n_err++; $display("FAIL ovf_empty_after: got %b want 1", empty_a); end
    endtask

    task automatic test_saturate;
        do_reset();
        rdy_a = 1'b0;
        load_rec(0);
        en_a = 1'b1;
        repeat (10) tick();   // 4 stored, 6 dropped
        n_cmp++; if (ovf_a !== 3'd6) begin n_err++; $display("FAIL sat_6: got %0d want 6", ovf_a); end
        tick();
        n_cmp++; if (ovf_a !== 3'd7) begin n_err++; $display("FAIL sat_7: got %0d want 7", ovf_a); end
        repeat (2) tick();
        n_cmp++; if (ovf_a !== 3'd7) begin n_err++; $display("FAIL sat_hold: got %0d want 7", ovf_a); end
        en_a = 1'b0;
    endtask

    task automatic test_filter;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h208; exp_w[1] = 32'h33; exp_w[2] = 32'h82; exp_w[3] = 32'h99;
        do_reset();
        set_rec(32'h200, 32'h11, 1'b0, 5'd3, 32'h77);
        en_b = 1'b1;
        tick();
        set_rec(32'h204, 32'h22, 1'b1, 5'd0, 32'h88);
        tick();
        en_b = 1'b0;
        n_cmp++; if (count_b !== 3'd0 || empty_b !== 1'b1) begin n_err++; $display("FAIL filt_skip: got count=%0d empty=%b want 0/1", count_b, empty_b); end
        n_cmp++; if (ovf_b !== 16'd0) begin n_err++; $display("FAIL filt_ovf: got %0d want 0", ovf_b); end
        set_rec(32'h208, 32'h33, 1'b1, 5'd2, 32'h99);
        en_b = 1'b1;
        tick();
        en_b = 1'b0;
        n_cmp++; if (count_b !== 3'd1) begin n_err++; $display("FAIL filt_count: got %0d want 1", count_b); end
        rdy_b = 1'b1;
        for (int w = 0; w < 4; w++) begin
            n_cmp++; if (data_b !== exp_w[w] || last_b !== (w == 3)) begin n_err++; $display("FAIL filt_data w%0d: got %h last=%b want %h", w, data_b, last_b, exp_w[w]); end
            tick();
        end
        n_cmp++; if (empty_b !== 1'b1) begin n_err++; $display("FAIL filt_empty_after: got %b want 1", empty_b); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        rdy_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_rec(i);
            en_a = 1'b1;
            tick();
        end
        en_a = 1'b0;
        n_cmp++; if (count_a !== 3'd2) begin n_err++; $display("FAIL b2b_count_pre: got %0d want 2", count_a); end
        rdy_a = 1'b1;
        for (int w = 0; w < 4; w++) begin
            if (w == 3) begin
                load_rec(2);
                en_a = 1'b1;
            end
            tick();
        end
        en_a = 1'b0;
        n_cmp++; if (count_a !== 3'd2) begin n_err++; $display("FAIL b2b_count_same: got %0d want 2", count_a); end
        for (int w = 0; w < 4; w++) begin
            n_cmp++; if (data_a !== rec_word(1, w, 1)) begin n_err++; $display("FAIL b2b_r1 w%0d: got %h want %h", w, data_a, rec_word(1, w, 1)); end
            tick();
        end
        n_cmp++; if (count_a !== 3'd1 || data_a !== rec_word(2, 0, 2)) begin n_err++; $display("FAIL b2b_r2_head: got count=%0d data=%h want 1/%h", count_a, data_a, rec_word(2, 0, 2)); end
        tick();   // W0 accepted
        tick();   // W1 accepted
        n_cmp++; if (data_a !== rec_word(2, 2, 2)) begin n_err++; $display("FAIL b2b_r2_w2: got %h want %h", data_a, rec_word(2, 2, 2)); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (valid_a !== 1'b0 || count_a !== 3'd0) begin n_err++; $display("FAIL midrec_reset: got valid=%b count=%0d want 0/0", valid_a, count_a); end
        load_rec(3);
        en_a = 1'b1;
        tick();
        en_a = 1'b0;
        n_cmp++; if (data_a !== rec_word(3, 0, 0) || count_a !== 3'd1) begin n_err++; $display("FAIL midrec_w0: got %h count=%0d want %h/1", data_a, count_a, rec_word(3, 0, 0)); end
        tick();
        tick();
        n_cmp++; if (data_a !== rec_word(3, 2, 0)) begin n_err++; $display("FAIL midrec_seq0: got %h want %h", data_a, rec_word(3, 2, 0)); end
        tick();
        tick();
        n_cmp++; if (empty_a !== 1'b1) begin n_err++; $display("FAIL midrec_empty_after: got %b want 1", empty_a); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        set_rec(32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) tick();
        test_reset();
        test_single_push();
        test_backpressure();
        test_overflow();
        test_saturate();
        test_filter();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
